// File: rtl/flit_mux_arb.sv
// flit_mux_arb: N:1 packet-locked flit multiplexer with registered valid/ready output
module flit_mux_arb #(
  parameter int NPORT = 4,
  parameter int DATAW = 66,
  parameter int VCHW  = 2,
  parameter int SELW  = 2,
  parameter int CNTW  = 32
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [NPORT*DATAW-1:0] idata,
  input  logic [NPORT-1:0]       ivalid,
  input  logic [NPORT*VCHW-1:0]  ivch,
  output logic [NPORT-1:0]       iready,
  input  logic                   mode,
  input  logic [SELW-1:0]        sel,
  output logic [DATAW-1:0]       odata,
  output logic                   ovalid,
  output logic [VCHW-1:0]        ovch,
  input  logic                   oready,
  output logic                   locked,
  output logic [SELW-1:0]        grant,
  output logic [CNTW-1:0]        flit_cnt,
  output logic                   err
);
  localparam int NS = 1 << SELW;
  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b11;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state_q, state_d;
  logic [DATAW-1:0] odata_q, odata_d;
  logic [VCHW-1:0] ovch_q, ovch_d;
  logic ovalid_q, ovalid_d, err_q, err_d;
  logic [SELW-1:0] grant_q, grant_d, cand, xport, idx;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [NS-1:0][DATAW-1:0] dat;
  logic [NS-1:0][VCHW-1:0] vc;
  logic [NS-1:0][1:0] ft;
  logic [NS-1:0] vld, rdy;
  logic out_free, cand_ok, xok, xfer;

  // unpack ports into arrays indexed by a SELW-bit port number; slots past NPORT stay idle
  always_comb begin
    dat = '0;
    vc = '0;
    ft = '0;
    vld = '0;
    for (int k = 0; k < NPORT; k++) begin
      dat[k] = idata[k*DATAW +: DATAW];
      vc[k] = ivch[k*VCHW +: VCHW];
      ft[k] = idata[k*DATAW+DATAW-2 +: 2];
      vld[k] = ivalid[k];
    end
  end

  // new-packet candidate: external select, or first valid HEAD after the last grant
  always_comb begin
    cand = sel;
    cand_ok = int'(sel) < NPORT;
    idx = '0;
    if (mode) begin
      cand_ok = 1'b0;
      for (int i = NPORT; i >= 1; i--) begin
        idx = SELW'((int'(grant_q) + i) % NPORT);
        if (vld[idx] && ft[idx] == T_HEAD) begin
          cand = idx;
          cand_ok = 1'b1;
        end
      end
    end
  end

  // accept handshake: the locked port follows out_free, otherwise only a valid HEAD candidate
  always_comb begin
    out_free = !ovalid_q || oready;
    xport = (state_q == LOCKED) ? grant_q : cand;
    xok = (state_q == LOCKED) || (cand_ok && vld[cand] && ft[cand] == T_HEAD);
    rdy = (rst_ && xok && out_free) ? NS'(1) << xport : '0;
    iready = rdy[NPORT-1:0];
    xfer = |(rdy & vld);
  end

  // packet lock tracking, protocol error detection, output register and transfer counter
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    err_d = err_q;
    if (state_q == IDLE && !mode && cand_ok && vld[cand] && ft[cand] != T_HEAD) err_d = 1'b1;
    if (xfer) begin
      if (state_q == IDLE) begin
        state_d = LOCKED;
        grant_d = cand;
      end else if (ft[xport] == T_TAIL) state_d = IDLE;
      else if (ft[xport] == T_HEAD || ft[xport] == T_NONE) err_d = 1'b1;
    end
    ovalid_d = xfer || (ovalid_q && !oready);
    odata_d = xfer ? dat[xport] : odata_q;
    ovch_d = xfer ? vc[xport] : ovch_q;
    cnt_d = (ovalid_q && oready && !(&cnt_q)) ? cnt_q + CNTW'(1) : cnt_q;
  end

  // state and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= IDLE;
      grant_q <= SELW'(NPORT-1);
      err_q <= 1'b0;
      ovalid_q <= 1'b0;
      odata_q <= '0;
      ovch_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      err_q <= err_d;
      ovalid_q <= ovalid_d;
      odata_q <= odata_d;
      ovch_q <= ovch_d;
      cnt_q <= cnt_d;
    end
  end

  assign odata = odata_q;
  assign ovalid = ovalid_q;
  assign ovch = ovch_q;
  assign locked = state_q == LOCKED;
  assign grant = grant_q;
  assign flit_cnt = cnt_q;
  assign err = err_q;
endmodule

// File: tb/tb_flit_mux_arb.sv
// tb_flit_mux_arb: directed and randomized checks of flit_mux_arb against a packet-level model
module tb_flit_mux_arb;
  localparam int NP = 4;
  localparam int DW = 66;
  localparam int VW = 2;
  localparam int SW = 2;
  localparam int CW = 5;
  localparam logic [1:0] NONE = 2'b00, HEAD = 2'b01, DATA = 2'b10, TAIL = 2'b11;

  logic clk = 1'b0;
  logic rst_;
  logic [NP*DW-1:0] idata;
  logic [NP-1:0] ivalid;
  logic [NP*VW-1:0] ivch;
  logic [NP-1:0] iready;
  logic mode;
  logic [SW-1:0] sel;
  logic [DW-1:0] odata;
  logic ovalid;
  logic [VW-1:0] ovch;
  logic oready;
  logic locked;
  logic [SW-1:0] grant;
  logic [CW-1:0] flit_cnt;
  logic err;

  flit_mux_arb #(.NPORT(NP), .DATAW(DW), .VCHW(VW), .SELW(SW), .CNTW(CW)) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch), .iready(iready),
    .mode(mode), .sel(sel), .odata(odata), .ovalid(ovalid), .ovch(ovch), .oready(oready),
    .locked(locked), .grant(grant), .flit_cnt(flit_cnt), .err(err)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] pq [NP][1024];
  logic [VW-1:0] pv [NP][1024];
  int rd [NP];
  int wr [NP];
  bit en [NP];

  bit m_ov, m_lk, m_err;
  logic [DW-1:0] m_od;
  logic [VW-1:0] m_vc;
  int m_g, m_cnt;

  int ncmp = 0;
  int nerr = 0;
  int exp_ord [5] = '{0, 1, 2, 3, 0};

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ftyp(int p);
    return pq[p][rd[p] % 1024][DW-1:DW-2];
  endfunction

  task automatic push(int p, logic [1:0] t);
    logic [DW-1:0] d;
    d = DW'({$urandom, $urandom, $urandom});
    d[DW-1:DW-2] = t;
    pq[p][wr[p] % 1024] = d;
    pv[p][wr[p] % 1024] = VW'($urandom);
    wr[p]++;
  endtask

  task automatic push_pkt(int p, int n, bit noisy);
    int r;
    push(p, HEAD);
    repeat (n) begin
      r = noisy ? int'($urandom_range(0, 29)) : 5;
      push(p, r == 0 ? NONE : r == 1 ? HEAD : DATA);
    end
    push(p, TAIL);
  endtask

  task automatic flush_all();
    for (int p = 0; p < NP; p++) rd[p] = wr[p];
  endtask

  // one clock: drive port fronts, check iready, advance model across the edge, check outputs
  task automatic step();
    int a, c;
    bit ofree;
    logic [NP-1:0] eir;
    logic [1:0] t;
    for (int p = 0; p < NP; p++) begin
      ivalid[p] = en[p] && rd[p] != wr[p];
      idata[p*DW +: DW] = rd[p] != wr[p] ? pq[p][rd[p] % 1024] : '0;
      ivch[p*VW +: VW] = rd[p] != wr[p] ? pv[p][rd[p] % 1024] : '0;
    end
    #1;
    a = -1;
    c = -1;
    eir = '0;
    ofree = !m_ov || oready;
    if (rst_) begin
      if (m_lk) begin
        eir[m_g] = ofree;
        if (ofree && ivalid[m_g]) a = m_g;
      end else begin
        if (!mode) c = int'(sel) < NP ? int'(sel) : -1;
        else for (int j = 1; j <= NP; j++)
          if (c < 0 && ivalid[(m_g + j) % NP] && ftyp((m_g + j) % NP) == HEAD) c = (m_g + j) % NP;
        if (c >= 0 && ivalid[c] && ofree && ftyp(c) == HEAD) begin
          eir[c] = 1'b1;
          a = c;
        end
      end
    end
    chk("iready", DW'(iready), DW'(eir));
    @(posedge clk);
    #1;
    if (!rst_) begin
      m_ov = 0; m_od = '0; m_vc = '0; m_lk = 0; m_g = NP - 1; m_cnt = 0; m_err = 0;
    end else begin
      if (m_ov && oready && m_cnt < (1 << CW) - 1) m_cnt++;
      if (!m_lk && !mode && c >= 0 && ivalid[c] && ftyp(c) != HEAD) m_err = 1;
      if (a >= 0) begin
        t = ftyp(a);
        m_od = pq[a][rd[a] % 1024];
        m_vc = pv[a][rd[a] % 1024];
        m_ov = 1;
        if (!m_lk) begin
          m_lk = 1;
          m_g = a;
        end else if (t == TAIL) m_lk = 0;
        else if (t == HEAD || t == NONE) m_err = 1;
        rd[a]++;
      end else if (oready) m_ov = 0;
    end
    chk("ovalid", DW'(ovalid), DW'(m_ov));
    if (m_ov) begin
      chk("odata", odata, m_od);
      chk("ovch", DW'(ovch), DW'(m_vc));
    end
    chk("locked", DW'(locked), DW'(m_lk));
    chk("grant", DW'(grant), DW'(m_g));
    chk("flit_cnt", DW'(flit_cnt), DW'(m_cnt));
    chk("err", DW'(err), DW'(m_err));
  endtask

  initial begin
    int nov, k;
    logic prevlk;
    logic [DW-1:0] hold;
    logic [CW-1:0] hc;
    logic [SW-1:0] got [5];
    rst_ = 0; mode = 0; sel = '0; oready = 1;
    for (int p = 0; p < NP; p++) begin
      rd[p] = 0; wr[p] = 0; en[p] = 0;
    end
    m_ov = 0; m_od = '0; m_vc = '0; m_lk = 0; m_g = NP - 1; m_cnt = 0; m_err = 0;
    repeat (2) step();
    chk("rst_ovalid", DW'(ovalid), 0);
    chk("rst_odata", odata, 0);
    chk("rst_grant", DW'(grant), 3);
    chk("rst_cnt", DW'(flit_cnt), 0);
    chk("rst_err", DW'(err), 0);
    chk("rst_locked", DW'(locked), 0);
    rst_ = 1;
    for (int p = 0; p < NP; p++) en[p] = 1;

    // one 22-flit packet through select 1
    sel = 2'd1;
    push_pkt(1, 20, 0);
    step();
    chk("p1_first", odata, pq[1][0]);
    nov = 1;
    repeat (26) begin
      step();
      nov += int'(ovalid);
    end
    chk("p1_len", DW'(nov), 22);
    chk("p1_cnt", DW'(flit_cnt), 22);
    chk("p1_unlock", DW'(locked), 0);

    // select moves mid-packet; then counter saturation
    push_pkt(1, 5, 0);
    push(2, HEAD);
    push(2, TAIL);
    repeat (3) step();
    sel = 2'd2;
    repeat (10) step();
    chk("sw_grant", DW'(grant), 2);
    chk("sw_cnt", DW'(flit_cnt), 31);
    sel = 2'd3;
    push(3, HEAD);
    push(3, TAIL);
    repeat (4) step();
    chk("sat_cnt", DW'(flit_cnt), 31);

    // round robin order from reset
    rst_ = 0;
    step();
    rst_ = 1;
    mode = 1;
    for (int p = 0; p < NP; p++) repeat (2) begin
      push(p, HEAD);
      push(p, TAIL);
    end
    k = 0;
    prevlk = 0;
    repeat (40) begin
      step();
      if (locked && !prevlk) begin
        if (k < 5) got[k] = grant;
        k++;
      end
      prevlk = locked;
    end
    chk("rr_count", DW'(k), 8);
    for (int i = 0; i < 5; i++) chk("rr_order", DW'(got[i]), DW'(exp_ord[i]));

    // downstream stall mid-packet
    mode = 0;
    sel = 2'd0;
    push_pkt(0, 6, 0);
    repeat (3) step();
    oready = 0;
    step();
    hold = odata;
    hc = flit_cnt;
    repeat (5) begin
      step();
      chk("stall_odata", odata, hold);
      chk("stall_ovalid", DW'(ovalid), 1);
      chk("stall_iready", DW'(iready), 0);
      chk("stall_cnt", DW'(flit_cnt), DW'(hc));
    end
    oready = 1;
    repeat (12) step();

    // DATA flit presented in IDLE under external select
    rst_ = 0;
    step();
    rst_ = 1;
    push(0, DATA);
    step();
    chk("bad_iready", DW'(iready), 0);
    chk("bad_err", DW'(err), 1);
    repeat (3) step();
    chk("bad_sticky", DW'(err), 1);
    flush_all();
    rst_ = 0;
    step();
    chk("bad_clear", DW'(err), 0);
    rst_ = 1;

    // reset while locked
    sel = 2'd1;
    push_pkt(1, 5, 0);
    repeat (3) step();
    chk("ml_locked", DW'(locked), 1);
    rst_ = 0;
    step();
    chk("ml_ovalid", DW'(ovalid), 0);
    chk("ml_locked0", DW'(locked), 0);
    chk("ml_grant", DW'(grant), 3);
    chk("ml_cnt", DW'(flit_cnt), 0);
    chk("ml_err", DW'(err), 0);
    rst_ = 1;
    flush_all();

    // randomized traffic
    for (int cy = 0; cy < 3000; cy++) begin
      if (cy % 64 == 0) mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) sel = SW'($urandom);
      oready = $urandom_range(0, 3) != 0;
      rst_ = $urandom_range(0, 199) != 0;
      for (int p = 0; p < NP; p++) begin
        en[p] = $urandom_range(0, 4) != 0;
        if (wr[p] - rd[p] < 4) push_pkt(p, int'($urandom_range(0, 3)), 1);
      end
      step();
      for (int p = 0; p < NP; p++)
        if (rd[p] != wr[p] && !(m_lk && m_g == p) && ftyp(p) != HEAD && $urandom_range(0, 3) == 0) rd[p]++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
